findmax_fsm: RTL

FINDMAX_FSM -- requirements
Module: findmax_fsm

---
 rtl/findmax_pkg.sv | 7 +
 rtl/findmax_lat_pipe.sv | 18 +
 rtl/findmax_fsm.sv | 72 +++++++
 3 files changed

// File: rtl/findmax_pkg.sv
// findmax_pkg: shared state encoding and default sizing for the BRAM max-finder
package findmax_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 1;
  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/findmax_lat_pipe.sv
// findmax_lat_pipe: DEPTH-stage 1-bit delay line with async active-low clear
module findmax_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/findmax_fsm.sv
// findmax_fsm: scans BRAM addresses 0..last_addr and flags the cycles where douta is a valid word
module findmax_fsm
  import findmax_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  output logic              clear_max,
  output logic              startFromFSM,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(RD_LAT) + 1;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, lim_q, lim_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              at_lim, cnt_end;
  assign at_lim  = addr_q == lim_q;
  assign cnt_end = cnt_q == CW'(RD_LAT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
    end
  // addr_q returns to 0 on the final READ so it never wraps and idles at 0
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lim_d   = lim_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        state_d = start ? CLEAR : IDLE;
        lim_d   = start ? last_addr : lim_q;
      end
      CLEAR: state_d = READ;
      READ: begin
        state_d = at_lim ? DRAIN : READ;
        addr_d  = at_lim ? '0 : addr_q + 1'b1;
      end
      DRAIN: begin
        state_d = cnt_end ? DONE : DRAIN;
        cnt_d   = cnt_end ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ena       = state_q == READ;
  assign addra     = addr_q;
  assign clear_max = state_q == CLEAR;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  findmax_lat_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk  (clk),
    .reset(reset),
    .d    (ena),
    .q    (startFromFSM)
  );
endmodule
